// File: rtl/gfx_wbm_read_arbiter_if.sv
// Bundle of requester-side and reader-side signals for gfx_wbm_read_arbiter.
// The master modport is the arbiter's view; slave is the environment's view.
interface gfx_wbm_read_arbiter_if #(
  parameter int MDW = 256
);
  logic           m0_request_i;
  logic [31:0]    m0_addr_i;
  logic [31:0]    m0_sel_i;
  logic           m0_ack_o;
  logic           m0_busy_o;
  logic           m1_request_i;
  logic [31:0]    m1_addr_i;
  logic [31:0]    m1_sel_i;
  logic           m1_ack_o;
  logic           m1_busy_o;
  logic           m2_request_i;
  logic [31:0]    m2_addr_i;
  logic [31:0]    m2_sel_i;
  logic           m2_ack_o;
  logic           m2_busy_o;
  logic [MDW-1:0] data_o;
  logic           master_request_o;
  logic [31:0]    master_addr_o;
  logic [31:0]    master_sel_o;
  logic           master_ack_i;
  logic [MDW-1:0] master_data_i;
  logic           master_busy_i;
  logic           timeout_o;

  modport master (
    input  m0_request_i, m0_addr_i, m0_sel_i,
    output m0_ack_o, m0_busy_o,
    input  m1_request_i, m1_addr_i, m1_sel_i,
    output m1_ack_o, m1_busy_o,
    input  m2_request_i, m2_addr_i, m2_sel_i,
    output m2_ack_o, m2_busy_o,
    output data_o, master_request_o, master_addr_o, master_sel_o, timeout_o,
    input  master_ack_i, master_data_i, master_busy_i
  );

  modport slave (
    output m0_request_i, m0_addr_i, m0_sel_i,
    input  m0_ack_o, m0_busy_o,
    output m1_request_i, m1_addr_i, m1_sel_i,
    input  m1_ack_o, m1_busy_o,
    output m2_request_i, m2_addr_i, m2_sel_i,
    input  m2_ack_o, m2_busy_o,
    input  data_o, master_request_o, master_addr_o, master_sel_o, timeout_o,
    output master_ack_i, master_data_i, master_busy_i
  );
endinterface

// File: rtl/gfx_wbm_read_arbiter.sv
// Three-way round-robin arbiter funnelling blender/texture/depth reads into one
// wishbone master reader, with a per-transaction ack timeout.
module gfx_wbm_read_arbiter #(
  parameter int MDW     = 256,
  parameter int TIMEOUT = 1023
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  gfx_wbm_read_arbiter_if.master  bus
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_ACK = 2'd1,
    S_RELEASE  = 2'd2
  } state_t;

  localparam logic [9:0] CNT_LAST = 10'(TIMEOUT - 1);

  state_t         state_q, state_d;
  logic [1:0]     grant_q, grant_d;
  logic [1:0]     last_grant_q, last_grant_d;
  logic [9:0]     cnt_q, cnt_d;
  logic           mreq_q, mreq_d;
  logic [31:0]    addr_q, addr_d;
  logic [31:0]    sel_q, sel_d;
  logic [2:0]     ack_q, ack_d;
  logic           timeout_q, timeout_d;
  logic [MDW-1:0] data_q, data_d;

  logic [2:0]     req_s;
  logic           win_valid_s;
  logic [1:0]     win_idx_s;
  logic [31:0]    win_addr_s;
  logic [31:0]    win_sel_s;

  function automatic logic [1:0] rr_idx(input logic [1:0] base, input logic [1:0] off);
    logic [2:0] sum;
    sum = {1'b0, base} + {1'b0, off};
    if (sum >= 3'd3) begin
      sum = sum - 3'd3;
    end else begin
      sum = sum;
    end
    return sum[1:0];
  endfunction

  function automatic logic req_at(input logic [2:0] req, input logic [1:0] idx);
    case (idx)
      2'd0:    return req[0];
      2'd1:    return req[1];
      2'd2:    return req[2];
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] onehot3(input logic [1:0] idx);
    case (idx)
      2'd0:    return 3'b001;
      2'd1:    return 3'b010;
      2'd2:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  assign req_s = {bus.m2_request_i, bus.m1_request_i, bus.m0_request_i};

  // Round-robin pick: the requester after the last winner has top priority.
  always_comb begin
    logic [1:0] c1, c2;
    c1          = rr_idx(last_grant_q, 2'd1);
    c2          = rr_idx(last_grant_q, 2'd2);
    win_valid_s = 1'b1;
    win_idx_s   = last_grant_q;
    if (req_at(req_s, c1)) begin
      win_idx_s = c1;
    end else if (req_at(req_s, c2)) begin
      win_idx_s = c2;
    end else if (req_at(req_s, last_grant_q)) begin
      win_idx_s = last_grant_q;
    end else begin
      win_valid_s = 1'b0;
    end
  end

  always_comb begin
    case (win_idx_s)
      2'd1:    begin win_addr_s = bus.m1_addr_i; win_sel_s = bus.m1_sel_i; end
      2'd2:    begin win_addr_s = bus.m2_addr_i; win_sel_s = bus.m2_sel_i; end
      default: begin win_addr_s = bus.m0_addr_i; win_sel_s = bus.m0_sel_i; end
    endcase
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    mreq_d       = mreq_q;
    addr_d       = addr_q;
    sel_d        = sel_q;
    data_d       = data_q;
    ack_d        = 3'b000;
    timeout_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (win_valid_s && !bus.master_busy_i) begin
          state_d = S_WAIT_ACK;
          grant_d = win_idx_s;
          addr_d  = win_addr_s;
          sel_d   = win_sel_s;
          mreq_d  = 1'b1;
          cnt_d   = 10'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT_ACK: begin
        // An ack on the final counted cycle still wins over the timeout.
        if (bus.master_ack_i) begin
          state_d      = S_RELEASE;
          mreq_d       = 1'b0;
          data_d       = bus.master_data_i;
          ack_d        = onehot3(grant_q);
          last_grant_d = grant_q;
        end else if (cnt_q >= CNT_LAST) begin
          state_d      = S_RELEASE;
          mreq_d       = 1'b0;
          data_d       = '0;
          ack_d        = onehot3(grant_q);
          timeout_d    = 1'b1;
          last_grant_d = grant_q;
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      S_RELEASE: begin
        state_d = S_IDLE;
        cnt_d   = 10'd0;
      end
      default: begin
        state_d = S_IDLE;
        mreq_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      grant_q      <= 2'd0;
      last_grant_q <= 2'd2;
      cnt_q        <= 10'd0;
      mreq_q       <= 1'b0;
      addr_q       <= 32'd0;
      sel_q        <= 32'd0;
      ack_q        <= 3'b000;
      timeout_q    <= 1'b0;
      data_q       <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      mreq_q       <= mreq_d;
      addr_q       <= addr_d;
      sel_q        <= sel_d;
      ack_q        <= ack_d;
      timeout_q    <= timeout_d;
      data_q       <= data_d;
    end
  end

  // Busy is combinational so a requester sees the reader's backpressure immediately in IDLE.
  always_comb begin
    bus.m0_busy_o = (state_q != S_IDLE) ? (grant_q != 2'd0) : bus.master_busy_i;
    bus.m1_busy_o = (state_q != S_IDLE) ? (grant_q != 2'd1) : bus.master_busy_i;
    bus.m2_busy_o = (state_q != S_IDLE) ? (grant_q != 2'd2) : bus.master_busy_i;
  end

  assign bus.m0_ack_o         = ack_q[0];
  assign bus.m1_ack_o         = ack_q[1];
  assign bus.m2_ack_o         = ack_q[2];
  assign bus.timeout_o        = timeout_q;
  assign bus.data_o           = data_q;
  assign bus.master_request_o = mreq_q;
  assign bus.master_addr_o    = addr_q;
  assign bus.master_sel_o     = sel_q;

endmodule

// File: tb/tb_gfx_wbm_read_arbiter.sv
// Directed bench for gfx_wbm_read_arbiter: a per-cycle vector table for
// arbitration/busy behaviour plus hand sequences for timeout and reset corners.
module tb_gfx_wbm_read_arbiter;
  localparam int MDW = 256;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  gfx_wbm_read_arbiter_if #(.MDW(MDW)) bus ();

  gfx_wbm_read_arbiter #(.MDW(MDW), .TIMEOUT(8)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  req;
    logic        mbusy;
    logic        mack;
    logic [7:0]  dbyte;
    logic        exp_mreq;
    logic [2:0]  exp_ack;
    logic [2:0]  exp_busy;
    logic [31:0] exp_addr;
    logic [7:0]  exp_data;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [2:0] req, input logic mbusy, input logic mack,
                              input logic [7:0] dbyte, input logic exp_mreq,
                              input logic [2:0] exp_ack, input logic [2:0] exp_busy,
                              input logic [31:0] exp_addr, input logic [7:0] exp_data);
    vec_t v;
    v.req = req; v.mbusy = mbusy; v.mack = mack; v.dbyte = dbyte;
    v.exp_mreq = exp_mreq; v.exp_ack = exp_ack; v.exp_busy = exp_busy;
    v.exp_addr = exp_addr; v.exp_data = exp_data;
    return v;
  endfunction

  function automatic logic [31:0] sel_for(input logic [31:0] addr);
    case (addr)
      32'h0000_1000: return 32'hFFFF_FFFF;
      32'h0000_2000: return 32'h0000_FFFF;
      32'h0000_3000: return 32'h0F0F_0F0F;
      default:       return 32'h0000_0000;
    endcase
  endfunction

  task automatic chk(input string name, input logic [MDW-1:0] act, input logic [MDW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic [2:0] req, input logic mbusy, input logic mack, input logic [7:0] dbyte);
    bus.m0_request_i  = req[0];
    bus.m1_request_i  = req[1];
    bus.m2_request_i  = req[2];
    bus.master_busy_i = mbusy;
    bus.master_ack_i  = mack;
    bus.master_data_i = {32{dbyte}};
  endtask

  function automatic logic [2:0] acks();
    return {bus.m2_ack_o, bus.m1_ack_o, bus.m0_ack_o};
  endfunction

  function automatic logic [2:0] busys();
    return {bus.m2_busy_o, bus.m1_busy_o, bus.m0_busy_o};
  endfunction

  initial begin
    int hi;
    logic fired;
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus.m0_addr_i = 32'h0000_1000; bus.m0_sel_i = 32'hFFFF_FFFF;
    bus.m1_addr_i = 32'h0000_2000; bus.m1_sel_i = 32'h0000_FFFF;
    bus.m2_addr_i = 32'h0000_3000; bus.m2_sel_i = 32'h0F0F_0F0F;
    drive(3'b000, 1'b0, 1'b0, 8'h00);

    //           req     mb    ack   byte   mreq  ack     busy    addr          data
    tbl.push_back(mk(3'b111, 1'b0, 1'b0, 8'h00, 1'b1, 3'b000, 3'b110, 32'h0000_1000, 8'h00));
    tbl.push_back(mk(3'b111, 1'b0, 1'b0, 8'h00, 1'b1, 3'b000, 3'b110, 32'h0000_1000, 8'h00));
    tbl.push_back(mk(3'b111, 1'b0, 1'b1, 8'hA5, 1'b0, 3'b001, 3'b110, 32'h0000_1000, 8'hA5));
    tbl.push_back(mk(3'b111, 1'b0, 1'b0, 8'h00, 1'b0, 3'b000, 3'b000, 32'h0000_1000, 8'hA5));
    tbl.push_back(mk(3'b111, 1'b0, 1'b0, 8'h00, 1'b1, 3'b000, 3'b101, 32'h0000_2000, 8'hA5));
    tbl.push_back(mk(3'b111, 1'b0, 1'b1, 8'h3C, 1'b0, 3'b010, 3'b101, 32'h0000_2000, 8'h3C));
    tbl.push_back(mk(3'b111, 1'b0, 1'b0, 8'h00, 1'b0, 3'b000, 3'b000, 32'h0000_2000, 8'h3C));
    tbl.push_back(mk(3'b111, 1'b0, 1'b0, 8'h00, 1'b1, 3'b000, 3'b011, 32'h0000_3000, 8'h3C));
    tbl.push_back(mk(3'b111, 1'b0, 1'b1, 8'h5A, 1'b0, 3'b100, 3'b011, 32'h0000_3000, 8'h5A));
    tbl.push_back(mk(3'b111, 1'b0, 1'b0, 8'h00, 1'b0, 3'b000, 3'b000, 32'h0000_3000, 8'h5A));
    tbl.push_back(mk(3'b111, 1'b0, 1'b0, 8'h00, 1'b1, 3'b000, 3'b110, 32'h0000_1000, 8'h5A));
    tbl.push_back(mk(3'b111, 1'b0, 1'b1, 8'hC3, 1'b0, 3'b001, 3'b110, 32'h0000_1000, 8'hC3));
    tbl.push_back(mk(3'b000, 1'b0, 1'b0, 8'h00, 1'b0, 3'b000, 3'b000, 32'h0000_1000, 8'hC3));
    tbl.push_back(mk(3'b000, 1'b0, 1'b1, 8'hFF, 1'b0, 3'b000, 3'b000, 32'h0000_1000, 8'hC3));
    for (int k = 0; k < 5; k++) begin
      tbl.push_back(mk(3'b010, 1'b1, 1'b0, 8'h00, 1'b0, 3'b000, 3'b111, 32'h0000_1000, 8'hC3));
    end
    tbl.push_back(mk(3'b010, 1'b0, 1'b0, 8'h00, 1'b1, 3'b000, 3'b101, 32'h0000_2000, 8'hC3));
    tbl.push_back(mk(3'b010, 1'b0, 1'b0, 8'h00, 1'b1, 3'b000, 3'b101, 32'h0000_2000, 8'hC3));
    tbl.push_back(mk(3'b010, 1'b0, 1'b1, 8'h96, 1'b0, 3'b010, 3'b101, 32'h0000_2000, 8'h96));
    tbl.push_back(mk(3'b000, 1'b0, 1'b0, 8'h00, 1'b0, 3'b000, 3'b000, 32'h0000_2000, 8'h96));

    // Reset state
    step();
    step();
    chk("rst_mreq", MDW'(bus.master_request_o), MDW'(1'b0));
    chk("rst_addr", MDW'(bus.master_addr_o), MDW'(32'd0));
    chk("rst_sel", MDW'(bus.master_sel_o), MDW'(32'd0));
    chk("rst_ack", MDW'(acks()), MDW'(3'b000));
    chk("rst_busy", MDW'(busys()), MDW'(3'b000));
    chk("rst_timeout", MDW'(bus.timeout_o), MDW'(1'b0));
    chk("rst_data", bus.data_o, '0);
    rst = 1'b0;

    // Table: inputs held for one cycle, outputs checked just after that edge
    foreach (tbl[i]) begin
      drive(tbl[i].req, tbl[i].mbusy, tbl[i].mack, tbl[i].dbyte);
      step();
      chk($sformatf("v%0d_mreq", i), MDW'(bus.master_request_o), MDW'(tbl[i].exp_mreq));
      chk($sformatf("v%0d_ack", i), MDW'(acks()), MDW'(tbl[i].exp_ack));
      chk($sformatf("v%0d_busy", i), MDW'(busys()), MDW'(tbl[i].exp_busy));
      chk($sformatf("v%0d_addr", i), MDW'(bus.master_addr_o), MDW'(tbl[i].exp_addr));
      chk($sformatf("v%0d_sel", i), MDW'(bus.master_sel_o), MDW'(sel_for(tbl[i].exp_addr)));
      chk($sformatf("v%0d_data", i), bus.data_o, {32{tbl[i].exp_data}});
      chk($sformatf("v%0d_timeout", i), MDW'(bus.timeout_o), MDW'(1'b0));
    end

    // Timeout on m2, which also drops its request mid-transaction
    drive(3'b100, 1'b0, 1'b0, 8'h00);
    step();
    chk("to_grant_mreq", MDW'(bus.master_request_o), MDW'(1'b1));
    chk("to_grant_addr", MDW'(bus.master_addr_o), MDW'(32'h0000_3000));
    drive(3'b000, 1'b0, 1'b0, 8'h00);
    hi = 1;
    fired = 1'b0;
    for (int c = 0; c < 20 && !fired; c++) begin
      step();
      if (bus.master_request_o) begin
        hi++;
        chk("to_wait_ack", MDW'(acks()), MDW'(3'b000));
        chk("to_wait_addr", MDW'(bus.master_addr_o), MDW'(32'h0000_3000));
      end else begin
        fired = 1'b1;
      end
    end
    chk("to_fired", MDW'(fired), MDW'(1'b1));
    chk("to_len", MDW'(hi), MDW'(8));
    chk("to_timeout", MDW'(bus.timeout_o), MDW'(1'b1));
    chk("to_ack", MDW'(acks()), MDW'(3'b100));
    chk("to_data", bus.data_o, '0);
    step();
    chk("to_timeout_pulse", MDW'(bus.timeout_o), MDW'(1'b0));
    chk("to_ack_pulse", MDW'(acks()), MDW'(3'b000));

    // Ack arriving on the last counted cycle is a normal ack
    drive(3'b001, 1'b0, 1'b0, 8'h00);
    step();
    chk("edge_grant_addr", MDW'(bus.master_addr_o), MDW'(32'h0000_1000));
    drive(3'b000, 1'b0, 1'b0, 8'h00);
    for (int c = 0; c < 7; c++) begin
      step();
      chk($sformatf("edge_hold%0d", c), MDW'(bus.master_request_o), MDW'(1'b1));
    end
    drive(3'b000, 1'b0, 1'b1, 8'h77);
    step();
    chk("edge_ack", MDW'(acks()), MDW'(3'b001));
    chk("edge_timeout", MDW'(bus.timeout_o), MDW'(1'b0));
    chk("edge_mreq", MDW'(bus.master_request_o), MDW'(1'b0));
    chk("edge_data", bus.data_o, {32{8'h77}});
    drive(3'b000, 1'b0, 1'b0, 8'h00);
    step();

    // Reset while waiting for the reader; a late ack must be ignored
    drive(3'b010, 1'b0, 1'b0, 8'h00);
    step();
    chk("mid_grant_mreq", MDW'(bus.master_request_o), MDW'(1'b1));
    chk("mid_grant_addr", MDW'(bus.master_addr_o), MDW'(32'h0000_2000));
    rst = 1'b1;
    step();
    chk("mid_rst_mreq", MDW'(bus.master_request_o), MDW'(1'b0));
    chk("mid_rst_addr", MDW'(bus.master_addr_o), MDW'(32'd0));
    chk("mid_rst_ack", MDW'(acks()), MDW'(3'b000));
    rst = 1'b0;
    drive(3'b000, 1'b0, 1'b1, 8'hEE);
    for (int c = 0; c < 2; c++) begin
      step();
      chk($sformatf("mid_late_ack%0d", c), MDW'(acks()), MDW'(3'b000));
      chk($sformatf("mid_late_mreq%0d", c), MDW'(bus.master_request_o), MDW'(1'b0));
      chk($sformatf("mid_late_data%0d", c), bus.data_o, '0);
    end
    drive(3'b111, 1'b0, 1'b0, 8'h00);
    step();
    chk("mid_next_addr", MDW'(bus.master_addr_o), MDW'(32'h0000_1000));
    chk("mid_next_busy", MDW'(busys()), MDW'(3'b110));
    drive(3'b111, 1'b0, 1'b1, 8'h11);
    step();
    chk("mid_next_ack", MDW'(acks()), MDW'(3'b001));
    chk("mid_next_data", bus.data_o, {32{8'h11}});
    drive(3'b000, 1'b0, 1'b0, 8'h00);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
